// File: rtl/linear_network_unicast_injector_pkg.sv
//------------------------------------------------------------------------------
// Module  : linear_network_unicast_injector_pkg
// Brief   : Shared defaults and the dest-tag width derivation for the injector.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package linear_network_unicast_injector_pkg;

    localparam int unsigned c_def_data_width = 32;
    localparam int unsigned c_def_num_node   = 4;

    // A single-node network still needs a 1-bit tag to keep the ports legal.
    function automatic int unsigned ln_cmd_width(input int unsigned num_node);
        return (num_node > 1) ? $clog2(num_node) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/linear_network_unicast_injector_sync_fifo.sv
//------------------------------------------------------------------------------
// Module  : linear_network_unicast_injector_sync_fifo
// Brief   : First-word-fall-through synchronous FIFO, power-of-two depth.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module linear_network_unicast_injector_sync_fifo #(
    parameter int unsigned WIDTH = 34,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [WIDTH-1:0]           i_din,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic [WIDTH-1:0]           o_dout
);

    localparam int unsigned c_ptr_w = $clog2(DEPTH);
    localparam int unsigned c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_depth = DEPTH[c_cnt_w-1:0];

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [c_ptr_w-1:0] rd_ptr_q;
    logic [c_ptr_w-1:0] wr_ptr_q;
    logic [c_cnt_w-1:0] count_q;
    logic               w_do_push;
    logic               w_do_pop;

    assign o_full    = (count_q == c_depth);
    assign o_empty   = (count_q == '0);
    assign o_count   = count_q;
    assign o_dout    = mem_q[rd_ptr_q];
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            mem_q[wr_ptr_q] <= i_din;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (w_do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/linear_network_unicast_injector.sv
//------------------------------------------------------------------------------
// Module  : linear_network_unicast_injector
// Brief   : Buffers (data, dest) words and issues one per enabled cycle into a
//           linear unicast network, tracking words still in flight.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module linear_network_unicast_injector
    import linear_network_unicast_injector_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = c_def_data_width,
    parameter int unsigned NUM_NODE      = c_def_num_node,
    parameter int unsigned COMMAND_WIDTH = ln_cmd_width(NUM_NODE),
    parameter int unsigned FIFO_DEPTH    = 8,
    parameter int unsigned CNT_WIDTH     = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [DATA_WIDTH-1:0]    i_data,
    input  logic [COMMAND_WIDTH-1:0] i_dest,
    input  logic                     i_stall,
    output logic                     o_valid,
    output logic [DATA_WIDTH-1:0]    o_data_bus,
    output logic [COMMAND_WIDTH-1:0] o_cmd,
    output logic                     o_en,
    output logic                     o_busy,
    output logic                     o_err_dest,
    output logic [CNT_WIDTH-1:0]     o_issue_cnt
);

    localparam int unsigned c_entry_w = DATA_WIDTH + COMMAND_WIDTH;
    localparam int unsigned c_cnt_w   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [COMMAND_WIDTH:0] c_num_node = NUM_NODE[COMMAND_WIDTH:0];

    logic                     w_full;
    logic                     w_empty;
    logic [c_cnt_w-1:0]       w_count;
    logic [c_cnt_w-1:0]       w_count_next;
    logic [c_entry_w-1:0]     w_head;
    logic                     w_push;
    logic                     w_dest_ok;
    logic                     w_store;
    logic                     w_pop;

    logic                     valid_q,   valid_d;
    logic [DATA_WIDTH-1:0]    data_q,    data_d;
    logic [COMMAND_WIDTH-1:0] cmd_q,     cmd_d;
    logic                     en_q,      en_d;
    logic                     busy_q,    busy_d;
    logic                     err_q,     err_d;
    logic [CNT_WIDTH-1:0]     cnt_q,     cnt_d;
    logic [NUM_NODE-1:0]      tracker_q, tracker_d;

    assign o_ready   = ~w_full;
    assign w_push    = i_valid & ~w_full;
    assign w_dest_ok = ({1'b0, i_dest} < c_num_node);
    assign w_store   = w_push & w_dest_ok;
    assign w_pop     = ~i_stall & ~w_empty;

    linear_network_unicast_injector_sync_fifo #(
        .WIDTH (c_entry_w),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_store),
        .i_pop   (w_pop),
        .i_din   ({i_data, i_dest}),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count),
        .o_dout  (w_head)
    );

    assign w_count_next = w_count + {{(c_cnt_w-1){1'b0}}, w_store}
                                  - {{(c_cnt_w-1){1'b0}}, w_pop};

    always_comb begin
        valid_d   = valid_q;
        data_d    = data_q;
        cmd_d     = cmd_q;
        cnt_d     = cnt_q;
        en_d      = ~i_stall;
        err_d     = w_push & ~w_dest_ok;
        tracker_d = en_q ? {tracker_q[NUM_NODE-2:0], valid_q} : tracker_q;
        if (!i_stall) begin
            if (!w_empty) begin
                valid_d = 1'b1;
                data_d  = w_head[c_entry_w-1:COMMAND_WIDTH];
                cmd_d   = w_head[COMMAND_WIDTH-1:0];
                cnt_d   = cnt_q + 1'b1;
            end else begin
                valid_d = 1'b0;
                data_d  = '0;
            end
        end
        // Built from next-state values so busy drops the edge the last word leaves.
        busy_d = (w_count_next != '0) | valid_d | (tracker_d != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            data_q    <= '0;
            cmd_q     <= '1;
            en_q      <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            tracker_q <= '0;
        end else begin
            valid_q   <= valid_d;
            data_q    <= data_d;
            cmd_q     <= cmd_d;
            en_q      <= en_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            tracker_q <= tracker_d;
        end
    end

    assign o_valid     = valid_q;
    assign o_data_bus  = data_q;
    assign o_cmd       = cmd_q;
    assign o_en        = en_q;
    assign o_busy      = busy_q;
    assign o_err_dest  = err_q;
    assign o_issue_cnt = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_linear_network_unicast_injector.sv
//------------------------------------------------------------------------------
// Module  : tb_linear_network_unicast_injector
// Brief   : Directed bench for the injector (default build plus a 3-node build).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_linear_network_unicast_injector;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        in_valid, in_stall;
    logic [31:0] in_data;
    logic [1:0]  in_dest;
    logic        out_ready, out_valid, out_en, out_busy, out_err;
    logic [31:0] out_data;
    logic [1:0]  out_cmd;
    logic [15:0] out_cnt;

    logic        d3_valid, d3_stall;
    logic [31:0] d3_data;
    logic [1:0]  d3_dest;
    logic        d3_ready, d3_ovalid, d3_en, d3_busy, d3_err;
    logic [31:0] d3_odata;
    logic [1:0]  d3_cmd;
    logic [3:0]  d3_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    linear_network_unicast_injector dut (
        .clk(clk), .rst_n(rst_n),
        .i_valid(in_valid), .o_ready(out_ready), .i_data(in_data), .i_dest(in_dest),
        .i_stall(in_stall), .o_valid(out_valid), .o_data_bus(out_data), .o_cmd(out_cmd),
        .o_en(out_en), .o_busy(out_busy), .o_err_dest(out_err), .o_issue_cnt(out_cnt)
    );

    linear_network_unicast_injector #(.NUM_NODE(3), .CNT_WIDTH(4)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .i_valid(d3_valid), .o_ready(d3_ready), .i_data(d3_data), .i_dest(d3_dest),
        .i_stall(d3_stall), .o_valid(d3_ovalid), .o_data_bus(d3_odata), .o_cmd(d3_cmd),
        .o_en(d3_en), .o_busy(d3_busy), .o_err_dest(d3_err), .o_issue_cnt(d3_cnt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check_reset();
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_data",  64'(out_data),  64'd0);
        check("rst_cmd",   64'(out_cmd),   64'd3);
        check("rst_en",    64'(out_en),    64'd0);
        check("rst_busy",  64'(out_busy),  64'd0);
        check("rst_err",   64'(out_err),   64'd0);
        check("rst_cnt",   64'(out_cnt),   64'd0);
        check("rst_ready", 64'(out_ready), 64'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; in_stall = 1'b0; in_data = '0; in_dest = '0;
        d3_valid = 1'b0; d3_stall = 1'b0; d3_data = '0; d3_dest = '0;
        step(); step();
        check_reset();

        // Single word, then busy must drop five edges after the issue edge.
        rst_n = 1'b1;
        in_valid = 1'b1; in_data = 32'hAAAA_AAAA; in_dest = 2'd1;
        step();
        check("single_pre_valid", 64'(out_valid), 64'd0);
        in_valid = 1'b0;
        step();
        check("single_valid", 64'(out_valid), 64'd1);
        check("single_cmd",   64'(out_cmd),   64'd1);
        check("single_data",  64'(out_data),  64'hAAAA_AAAA);
        check("single_en",    64'(out_en),    64'd1);
        check("single_cnt",   64'(out_cnt),   64'd1);
        step();
        check("single_dummy_valid", 64'(out_valid), 64'd0);
        check("single_dummy_data",  64'(out_data),  64'd0);
        step(); step(); step();
        check("single_busy_hold", 64'(out_busy), 64'd1);
        step();
        check("single_busy_fall", 64'(out_busy), 64'd0);

        // Fill under stall; the ninth word is refused.
        in_stall = 1'b1;
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1; in_data = 32'h1000 + i; in_dest = 2'(i % 4);
            step();
        end
        check("fill_ready", 64'(out_ready), 64'd0);
        check("fill_en",    64'(out_en),    64'd0);
        check("fill_valid", 64'(out_valid), 64'd0);
        check("fill_busy",  64'(out_busy),  64'd1);
        in_valid = 1'b0; in_stall = 1'b0;
        for (int j = 0; j < 8; j++) begin
            step();
            check("fill_drain_valid", 64'(out_valid), 64'd1);
            check("fill_drain_data",  64'(out_data),  64'h1000 + 64'(j));
            check("fill_drain_cmd",   64'(out_cmd),   64'(j % 4));
        end
        step();
        check("fill_end_valid", 64'(out_valid), 64'd0);
        check("fill_cnt",       64'(out_cnt),   64'd9);

        // Stall mid-burst for three cycles.
        in_valid = 1'b1; in_data = 32'hB0; in_dest = 2'd3;
        step();
        in_data = 32'hB1; in_dest = 2'd2;
        step();
        check("burst_w0_data", 64'(out_data), 64'hB0);
        check("burst_w0_cmd",  64'(out_cmd),  64'd3);
        in_valid = 1'b0;
        step();
        check("burst_w1_data", 64'(out_data), 64'hB1);
        check("burst_w1_cmd",  64'(out_cmd),  64'd2);
        in_stall = 1'b1; in_valid = 1'b1; in_data = 32'hB2; in_dest = 2'd1;
        step();
        check("stall1_en",   64'(out_en),    64'd0);
        check("stall1_data", 64'(out_data),  64'hB1);
        check("stall1_valid", 64'(out_valid), 64'd1);
        in_data = 32'hB3; in_dest = 2'd0;
        step();
        check("stall2_en",   64'(out_en),   64'd0);
        check("stall2_cmd",  64'(out_cmd),  64'd2);
        in_valid = 1'b0;
        step();
        check("stall3_data", 64'(out_data), 64'hB1);
        in_stall = 1'b0;
        step();
        check("burst_w2_data", 64'(out_data), 64'hB2);
        check("burst_w2_cmd",  64'(out_cmd),  64'd1);
        check("burst_w2_en",   64'(out_en),   64'd1);
        step();
        check("burst_w3_data", 64'(out_data), 64'hB3);
        check("burst_w3_cmd",  64'(out_cmd),  64'd0);
        step(); step(); step(); step();
        check("burst_busy_hold", 64'(out_busy), 64'd1);
        step();
        check("burst_busy_fall", 64'(out_busy), 64'd0);

        // Full FIFO with a simultaneous pop: push refused, then accepted.
        in_stall = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_data = 32'hC0 + i; in_dest = 2'd2;
            step();
        end
        check("full_ready", 64'(out_ready), 64'd0);
        in_stall = 1'b0; in_data = 32'hCC; in_dest = 2'd3;
        step();
        check("full_pop_data",  64'(out_data),  64'hC0);
        check("full_pop_ready", 64'(out_ready), 64'd1);
        step();
        check("full_next_data", 64'(out_data),  64'hC1);
        in_valid = 1'b0;
        for (int j = 2; j < 8; j++) begin
            step();
            check("full_drain_data", 64'(out_data), 64'hC0 + 64'(j));
        end
        step();
        check("full_late_data", 64'(out_data), 64'hCC);
        check("full_late_cmd",  64'(out_cmd),  64'd3);
        step();
        check("full_end_valid", 64'(out_valid), 64'd0);
        check("full_cnt",       64'(out_cnt),   64'd22);

        // Reset with buffered words pending.
        in_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 32'hD0 + i; in_dest = 2'd1;
            step();
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        step(); step();
        check_reset();
        rst_n = 1'b1; in_stall = 1'b0;
        step();
        check("post_rst_en",    64'(out_en),    64'd1);
        check("post_rst_valid", 64'(out_valid), 64'd0);
        step();
        check("post_rst_flushed", 64'(out_valid), 64'd0);
        check("post_rst_busy",    64'(out_busy),  64'd0);

        // Three-node build: out-of-range dest and counter wrap.
        d3_valid = 1'b1; d3_data = 32'hDEAD; d3_dest = 2'd3;
        step();
        check("d3_err_pulse", 64'(d3_err),   64'd1);
        check("d3_err_ready", 64'(d3_ready), 64'd1);
        d3_valid = 1'b0;
        step();
        check("d3_err_clear",   64'(d3_err),    64'd0);
        check("d3_err_novalid", 64'(d3_ovalid), 64'd0);
        check("d3_err_cnt",     64'(d3_cnt),    64'd0);
        check("d3_err_busy",    64'(d3_busy),   64'd0);
        for (int i = 0; i < 16; i++) begin
            d3_valid = 1'b1; d3_data = 32'(i); d3_dest = 2'(i % 3);
            step();
        end
        check("d3_cnt_max", 64'(d3_cnt), 64'hF);
        d3_valid = 1'b0;
        step();
        check("d3_cnt_wrap", 64'(d3_cnt),   64'd0);
        check("d3_last_data", 64'(d3_odata), 64'd15);
        check("d3_last_cmd",  64'(d3_cmd),   64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
